// File: rtl/pipelining_multi_if.sv
// Operand/result bundle for the pipelined shift-and-add multiplier.
// master drives operands and en; slave (the multiplier) returns result and rdy.
interface pipelining_multi_if #(
  parameter int M = 7,
  parameter int N = 4
) ();
  logic [M-1:0]   multi1;
  logic [N-1:0]   multi2;
  logic           en;
  logic [M+N-1:0] result;
  logic           rdy;

  modport master (output multi1, multi2, en, input result, rdy);
  modport slave  (input multi1, multi2, en, output result, rdy);
endinterface

// File: rtl/pipelining_multi.sv
// Fully pipelined unsigned M x N shift-and-add multiplier, one stage per multiplier bit.
// Each stage carries its own copy of the operands, so a new pair is accepted every clock.
// Optional macro PIPELINING_MULTI_OUTREG_EN adds one output register (latency N+1 edges).
module pipelining_multi #(
  parameter int M = 7,
  parameter int N = 4
) (
  input logic              clk,
  input logic              rst_n,
  pipelining_multi_if.slave bus
);
  localparam int W = M + N;

  logic [M-1:0] mcand_q  [N];
  logic [N-1:0] mplier_q [N];
  logic [W-1:0] psum_q   [N];
  logic         valid_q  [N];

  for (genvar k = 0; k < N; k++) begin : g_stage
    if (k == 0) begin : g_first
      // Stage 0 captures the port operands and adds the bit-0 partial product.
      // When it is also the last stage, the sum only moves on valid input so result holds.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          mcand_q[0]  <= '0;
          mplier_q[0] <= '0;
          psum_q[0]   <= '0;
          valid_q[0]  <= 1'b0;
        end else begin
          mcand_q[0]  <= bus.multi1;
          mplier_q[0] <= bus.multi2;
          valid_q[0]  <= bus.en;
          if (N > 1 || bus.en)
            psum_q[0] <= bus.multi2[0] ? W'(bus.multi1) : {W{1'b0}};
        end
      end
    end else begin : g_next
      // Stage k adds multiplicand<<k when multiplier bit k is set; the final stage
      // holds its sum across bubbles so the output keeps the last valid product.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          mcand_q[k]  <= '0;
          mplier_q[k] <= '0;
          psum_q[k]   <= '0;
          valid_q[k]  <= 1'b0;
        end else begin
          mcand_q[k]  <= mcand_q[k-1];
          mplier_q[k] <= mplier_q[k-1];
          valid_q[k]  <= valid_q[k-1];
          if (k < N-1 || valid_q[k-1])
            psum_q[k] <= psum_q[k-1] +
                         (mplier_q[k-1][k] ? (W'(mcand_q[k-1]) << k) : {W{1'b0}});
        end
      end
    end
  end

`ifdef PIPELINING_MULTI_OUTREG_EN
  logic [W-1:0] result_q;
  logic         rdy_q;

  // Extra output register: rdy follows the final valid one clock later, result
  // only reloads on a valid product.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      rdy_q    <= 1'b0;
    end else begin
      rdy_q <= valid_q[N-1];
      if (valid_q[N-1])
        result_q <= psum_q[N-1];
    end
  end

  assign bus.result = result_q;
  assign bus.rdy    = rdy_q;
`else
  assign bus.result = psum_q[N-1];
  assign bus.rdy    = valid_q[N-1];
`endif

endmodule

// File: tb/tb_pipelining_multi.sv
// Directed bench for pipelining_multi (M=7, N=4). Expected products are hand values
// (or a*b in the sweep) carried through a delay line of the expected latency.
module tb_pipelining_multi;
  localparam int M = 7;
  localparam int N = 4;
  localparam int W = M + N;
`ifdef PIPELINING_MULTI_OUTREG_EN
  localparam int LAT = N;
`else
  localparam int LAT = N - 1;
`endif

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_err;

  logic         line_v [0:LAT];
  logic [W-1:0] line_p [0:LAT];
  logic [W-1:0] exp_res;

  pipelining_multi_if #(.M(M), .N(N)) bus ();

  pipelining_multi #(.M(M), .N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i <= LAT; i++) begin
      line_v[i] = 1'b0;
      line_p[i] = '0;
    end
    exp_res = '0;
  endtask

  // Called just after a falling edge: drive one input cycle, wait through the next
  // rising edge, then compare outputs against the entry captured LAT edges earlier.
  task automatic step(input string tag, input logic e, input int a, input int b, input int p);
    bus.en     = e;
    bus.multi1 = M'(a);
    bus.multi2 = N'(b);
    for (int i = LAT; i > 0; i--) begin
      line_v[i] = line_v[i-1];
      line_p[i] = line_p[i-1];
    end
    line_v[0] = e;
    line_p[0] = W'(p);
    @(negedge clk);
    if (line_v[LAT])
      exp_res = line_p[LAT];
    check_val({tag, "_rdy"}, 32'(bus.rdy), 32'(line_v[LAT]));
    check_val({tag, "_result"}, 32'(bus.result), 32'(exp_res));
  endtask

  task automatic flush(input string tag);
    for (int i = 0; i <= LAT; i++)
      step(tag, 1'b0, 85, 6, 0);
  endtask

  // Pull reset mid-cycle, check outputs clear before any clock edge, release on a falling edge.
  task automatic async_reset(input string tag);
    #2 rst_n = 1'b0;
    #1;
    check_val({tag, "_rdy"}, 32'(bus.rdy), 32'd0);
    check_val({tag, "_result"}, 32'(bus.result), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    clear_model();
  endtask

  int sweep_b [7] = '{7, 1, 15, 3, 11, 4, 9};

  initial begin
    n_checks = 0;
    n_err    = 0;
    rst_n      = 1'b0;
    bus.en     = 1'b0;
    bus.multi1 = '0;
    bus.multi2 = '0;
    clear_model();

    // 1) reset held for 5 cycles
    repeat (5) @(negedge clk);
    check_val("rst_rdy", 32'(bus.rdy), 32'd0);
    check_val("rst_result", 32'(bus.result), 32'd0);
    rst_n = 1'b1;

    // 2) back-to-back pairs
    step("b2b", 1'b1, 25, 5, 125);
    step("b2b", 1'b1, 16, 10, 160);
    step("b2b", 1'b1, 10, 4, 40);
    step("b2b", 1'b1, 15, 7, 105);
    flush("b2b_flush");

    // 1b) asynchronous reset while result is non-zero
    async_reset("async_rst");
    flush("post_rst");

    // 3) sweep with multi1 wrapping through 127 -> 0
    for (int i = 0; i < 32; i++) begin
      int a;
      int b;
      a = (110 + i) % 128;
      b = sweep_b[i % 7];
      step("sweep", 1'b1, a, b, a * b);
    end
    flush("sweep_flush");

    // 4) corners
    step("corner", 1'b1, 127, 15, 1905);
    step("corner", 1'b1, 0, 15, 0);
    step("corner", 1'b1, 127, 0, 0);
    step("corner", 1'b1, 1, 1, 1);
    flush("corner_flush");

    // 5) bubbles 1,0,1,1,0
    step("bubble", 1'b1, 100, 3, 300);
    step("bubble", 1'b0, 77, 9, 0);
    step("bubble", 1'b1, 12, 12, 144);
    step("bubble", 1'b1, 9, 13, 117);
    step("bubble", 1'b0, 50, 5, 0);
    flush("bubble_flush");

    // 6) reset with three operations in flight
    step("inflight", 1'b1, 33, 3, 99);
    step("inflight", 1'b1, 44, 2, 88);
    step("inflight", 1'b1, 55, 15, 825);
    async_reset("mid_rst");
    flush("mid_rst_idle");
    step("after_rst", 1'b1, 21, 6, 126);
    flush("after_rst_flush");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
